// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, frame defaults, oversample rate.
package uart_pkg;

  localparam int unsigned OVERSAMPLE         = 16;
  localparam int unsigned DBIT_DEFAULT       = 8;
  localparam int unsigned SB_TICK_DEFAULT    = 16;
  localparam int unsigned PARITY_ODD_DEFAULT = 0;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two-stage capture; the second stage is the only one consumed downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx_parity.sv
// UART receiver: start, DBIT data bits LSB-first, one parity bit, stop.
// Delivers every frame with a one-cycle done strobe plus parity/framing flags.
module uart_rx_parity
  import uart_pkg::*;
#(
  parameter int unsigned DBIT       = DBIT_DEFAULT,
  parameter int unsigned SB_TICK    = SB_TICK_DEFAULT,
  parameter int unsigned PARITY_ODD = PARITY_ODD_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            rx,
  input  logic            s_tick,
  output logic [DBIT-1:0] dout,
  output logic            rx_done_tick,
  output logic            parity_err,
  output logic            frame_err
);

  // Tick counter must reach SB_TICK-1 for 1.5/2 stop bits, so widen past 4 bits when needed.
  localparam int unsigned SW = (SB_TICK > OVERSAMPLE) ? $clog2(SB_TICK) : $clog2(OVERSAMPLE);
  localparam int unsigned NW = $clog2(DBIT);

  localparam logic [SW-1:0] S_MID      = SW'(OVERSAMPLE / 2 - 1);
  localparam logic [SW-1:0] S_LAST     = SW'(OVERSAMPLE - 1);
  localparam logic [SW-1:0] S_STOP     = SW'(SB_TICK - 1);
  localparam logic [NW-1:0] N_LAST     = NW'(DBIT - 1);
  localparam logic          PAR_ODD    = 1'(PARITY_ODD);

  logic            rx_s;
  rx_state_e       state_q, state_d;
  logic [SW-1:0]   s_q, s_d;
  logic [NW-1:0]   n_q, n_d;
  logic [DBIT-1:0] b_q, b_d;
  logic            p_q, p_d;
  logic [DBIT-1:0] dout_q, dout_d;
  logic            done_q, done_d;
  logic            perr_q, perr_d;
  logic            ferr_q, ferr_d;

  // Bring the idle-high serial line into the clk domain.
  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx),
    .q_o   (rx_s)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      p_q     <= 1'b0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      p_q     <= p_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // Frame sequencing; each bit is sampled at the centre tick of its 16-tick window.
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    p_d     = p_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    perr_d  = perr_q;
    ferr_d  = ferr_q;

    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d = ST_START;
          s_d     = '0;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == S_MID) begin
            if (rx_s) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_DATA;
              s_d     = '0;
              n_d     = '0;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            s_d = '0;
            b_d = {rx_s, b_q[DBIT-1:1]};
            if (n_q == N_LAST) begin
              state_d = ST_PARITY;
            end else begin
              n_d = n_q + NW'(1);
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == S_LAST) begin
            p_d     = rx_s;
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_q == S_STOP) begin
            state_d = ST_IDLE;
            dout_d  = b_q;
            perr_d  = (^b_q) ^ p_q ^ PAR_ODD;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign dout         = dout_q;
  assign rx_done_tick = done_q;
  assign parity_err   = perr_q;
  assign frame_err    = ferr_q;

endmodule

// File: doc/uart_rx_parity.md
# uart_rx_parity

Serial receiver for the parity UART. It sits directly upstream of the receive FIFO inside the `uart` block. It oversamples the `rx` line using the shared baud tick and deserialises one frame: start, DBIT data bits LSB-first, one parity bit, stop. It then presents the byte with a one-cycle done strobe and registered parity and framing error flags; these flags drive the board-level error display.

## Interface
Parameters:
- `DBIT`, 8: data bits per frame, 5..8.
- `SB_TICK`, 16: `s_tick` count for the stop bit (16 = 1 stop, 24 = 1.5, 32 = 2).
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity.

Ports:
- `clk` in 1: system clock. One clock domain; everything is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `rx` in 1: raw serial line, idle high, asynchronous to `clk`.
- `s_tick` in 1: one-cycle enable at 16× the baud rate, from the baud generator.
- `dout` out DBIT: last received byte.
- `rx_done_tick` out 1: one-cycle pulse when `dout` is updated.
- `parity_err` out 1: parity result of the last frame.
- `frame_err` out 1: stop-bit result of the last frame.

## Operation
Input and counters:
- `rx` passes through a 2-flop synchronizer to give `rx_s`. All decisions use `rx_s`.
- Registers:
  - state
  - `s` (4-bit tick counter)
  - `n` (data bit index)
  - `b` (DBIT shift register)
  - `p` (parity sample)

State machine:
- IDLE: when `rx_s`=0, go to START with `s`=0. `s_tick` is ignored in IDLE.
- START, on each `s_tick`:
  - At `s`=7 (mid start bit), if `rx_s`=1 it is a glitch: return to IDLE with no output activity.
  - Otherwise go to DATA with `s`=0, `n`=0.
  - Below 7, increment `s`.
- DATA, on each `s_tick`:
  - At `s`=15: `s`=0 and `b` = {`rx_s`, `b`[DBIT-1:1]}.
  - If `n`=DBIT-1, go to PARITY; otherwise increment `n`.
- PARITY, on each `s_tick`: at `s`=15, `p`=`rx_s`, `s`=0, go to STOP.
- STOP, on each `s_tick`: at `s`=SB_TICK-1, do all of the following, then go to IDLE:
  - `dout`←`b`
  - `parity_err`←(^`b` ^ `p` ^ `PARITY_ODD`)
  - `frame_err`←~`rx_s`
  - `rx_done_tick`←1
- Error handling:
  - A frame with `parity_err` or `frame_err` set is still delivered: `dout` updates and the done strobe fires.
  - The error flags hold until the next frame completes.

## Timing
Reset values:
- `dout`=0, `parity_err`=0, `frame_err`=0, `rx_done_tick`=0.
- State IDLE; `s`, `n`, `b`, `p` all 0.
- Synchronizer flops reset to 1.

Latency:
- The falling edge of `rx` is seen in IDLE 2 clocks later.
- From entering START, the frame completes after 8 + 16·DBIT + 16 + SB_TICK `s_tick`s.
- `rx_done_tick`, `dout` and the flags are all registered. They become valid in the clock after the final STOP `s_tick`, in the same cycle as each other.

Boundary conditions:
- `rx_done_tick` is high for exactly one `clk`, even if `s_tick` stays high continuously.
- A new falling edge in the same cycle as the return to IDLE is detected on the next cycle. No frame is lost at back-to-back frame rates.
- Reset asserted mid-frame: the next cycle is IDLE with all outputs at reset values. No done pulse. The partial frame is discarded.
- `rx` held low permanently:
  - That frame completes with `frame_err`=1.
  - The block then re-enters START immediately and keeps reporting framing errors.
  - It never hangs.

## Structure
- Shared `uart_pkg` holds:
  - state encoding constants (IDLE, START, DATA, PARITY, STOP; 3-bit)
  - the default DBIT, SB_TICK and PARITY_ODD values
  - the oversample constant 16
- One sub-module, `sync_2ff`, is used for `rx`. It has a parameterisable reset value and is reused for the button and other asynchronous inputs.
- The baud generator is external and is shared with the transmitter.

## Test plan
Common setup: `s_tick` tied high; DBIT=8, SB_TICK=16.

- Even parity: frame 0xA5, parity bit 0, stop 1 → single `rx_done_tick`, `dout`=0xA5, `parity_err`=0, `frame_err`=0.
- Even parity: 0xA5 with parity bit 1 → `dout`=0xA5, `parity_err`=1. Then 0x07 with parity bit 1 → `parity_err` returns to 0.
- PARITY_ODD=1: 0x07 with parity bit 0 → `parity_err`=0. Then 0x00 with parity bit 0 → `parity_err`=1.
- Stop bit driven 0 on 0x3C → `dout`=0x3C, `frame_err`=1. Next frame 0x3C with valid stop → `frame_err`=0.
- Glitch: `rx` low for 4 `s_tick`s, then high → no `rx_done_tick`, outputs unchanged, state IDLE. A following 0x5A frame is received correctly.
- Reset pulse during data bit 3 of 0xFF → outputs at 0, no done pulse. A following 0x81 frame gives `dout`=0x81 with no errors.
